// File: rtl/uart_rx_pkg.sv
// Shared types, sampling constants and the divider helper for the frequency-setpoint UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned SAMPLE_LO     = 7;
    localparam int unsigned SAMPLE_MID    = 8;
    localparam int unsigned SAMPLE_HI     = 9;
    localparam int unsigned TICKS_PER_BIT = 16;
    localparam logic [7:0]  RX_RESET      = 8'd60;

    // Rounded clocks per 16x oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample divider; clr_i restarts the count so ticks line up with a new frame.
module uart_baud_tick #(
    parameter int unsigned Div = 326
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntMax);
        cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frec.sv
// 8N1 oversampling receiver that range-checks each byte before loading it as a frequency setpoint.
module uart_rx_frec
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned FMIN   = 1,
    parameter int unsigned FMAX   = 250
) (
    input  logic       clock,
    input  logic       Restablecer,
    input  logic       SerialIn,
    output logic [7:0] Rx,
    output logic       Selec,
    output logic       ErrTrama,
    output logic       FueraRango
);

    localparam int unsigned Div = calc_div(CLK_HZ, BAUD);

    logic       sync1_q, sin_q;
    rx_state_e  state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] rx_q, rx_d;
    logic       selec_q, selec_d, err_q, err_d, fuera_q, fuera_d;
    logic       clr, tick, maj, lo_ok, hi_ok;

    uart_baud_tick #(
        .Div(Div)
    ) u_baud_tick (
        .clk_i (clock),
        .rst_ni(Restablecer),
        .clr_i (clr),
        .tick_o(tick)
    );

    // Bounds at the edges of the byte range are dropped rather than compared.
    if (FMIN == 0) begin : g_lo_all
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = ({24'd0, shift_q} >= FMIN);
    end
    if (FMAX >= 255) begin : g_hi_all
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = ({24'd0, shift_q} <= FMAX);
    end

    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & sin_q) | (smp_q[1] & sin_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        rx_d    = rx_q;
        selec_d = 1'b0;
        err_d   = 1'b0;
        fuera_d = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!sin_q) begin
                    state_d = StStart;
                    clr     = 1'b1;
                    s_d     = '0;
                    bit_d   = '0;
                end
            end
            StStart, StData, StStop: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'(SAMPLE_LO))  smp_d[0] = sin_q;
                    if (s_q == 4'(SAMPLE_MID)) smp_d[1] = sin_q;
                    if (state_q == StStart) begin
                        if (s_q == 4'(SAMPLE_HI) && maj) begin
                            state_d = StIdle;
                        end else if (s_q == 4'(TICKS_PER_BIT - 1)) begin
                            state_d = StData;
                        end
                    end else if (state_q == StData) begin
                        if (s_q == 4'(SAMPLE_HI)) shift_d = {maj, shift_q[7:1]};
                        if (s_q == 4'(TICKS_PER_BIT - 1)) begin
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) state_d = StStop;
                        end
                    end else if (s_q == 4'(SAMPLE_HI)) begin
                        // Good stop returns to idle at its midpoint so a prompt next start is caught.
                        if (maj) begin
                            state_d = StIdle;
                            if (lo_ok && hi_ok) begin
                                rx_d    = shift_q;
                                selec_d = 1'b1;
                            end else begin
                                fuera_d = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = StBreak;
                        end
                    end
                end
            end
            StBreak: begin
                if (sin_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!Restablecer) begin
            sync1_q <= 1'b1;
            sin_q   <= 1'b1;
            state_q <= StIdle;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            smp_q   <= '0;
            rx_q    <= RX_RESET;
            selec_q <= 1'b0;
            err_q   <= 1'b0;
            fuera_q <= 1'b0;
        end else begin
            sync1_q <= SerialIn;
            sin_q   <= sync1_q;
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            rx_q    <= rx_d;
            selec_q <= selec_d;
            err_q   <= err_d;
            fuera_q <= fuera_d;
        end
    end

    assign Rx         = rx_q;
    assign Selec      = selec_q;
    assign ErrTrama   = err_q;
    assign FueraRango = fuera_q;

endmodule

// File: tb/tb_uart_rx_frec.sv
// Directed bench for uart_rx_frec at 614.4 kHz / 9600 baud (4 clocks per tick, 64 per bit).
module tb_uart_rx_frec;

    localparam int BitClk  = 64;
    localparam int FastClk = 62;  // ~+3 % baud

    logic       clock = 1'b0;
    logic       Restablecer = 1'b0;
    logic       SerialIn = 1'b1;
    logic [7:0] Rx;
    logic       Selec, ErrTrama, FueraRango;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] at;
        logic [1:0]  kind;  // 1 Selec, 2 ErrTrama, 3 FueraRango
        logic [7:0]  rx;
    } ev_t;
    ev_t evq[$];

    uart_rx_frec #(
        .CLK_HZ(614_400),
        .BAUD  (9600),
        .FMIN  (1),
        .FMAX  (250)
    ) dut (
        .clock      (clock),
        .Restablecer(Restablecer),
        .SerialIn   (SerialIn),
        .Rx         (Rx),
        .Selec      (Selec),
        .ErrTrama   (ErrTrama),
        .FueraRango (FueraRango)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (Selec)      evq.push_back({cyc, 2'd1, Rx});
        if (ErrTrama)   evq.push_back({cyc, 2'd2, Rx});
        if (FueraRango) evq.push_back({cyc, 2'd3, Rx});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic drive_bit(input logic v, input int n);
        SerialIn = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int n, input logic stop_v);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(b[i], n);
        drive_bit(stop_v, n);
    endtask

    task automatic apply_reset;
        SerialIn = 1'b1;
        Restablecer = 1'b0;
        repeat (3) @(negedge clock);
        Restablecer = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset;
        int base;
        SerialIn = 1'b1;
        Restablecer = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (Rx !== 8'd60) begin
            errors++;
            $display("FAIL reset_rx: got %0d expected 60", Rx);
        end
        checks++;
        if ({Selec, ErrTrama, FueraRango} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000", {Selec, ErrTrama, FueraRango});
        end
        Restablecer = 1'b1;
        base = evq.size();
        repeat (100) @(negedge clock);
        checks++;
        if (evq.size() - base !== 0) begin
            errors++;
            $display("FAIL reset_idle_events: got %0d expected 0", evq.size() - base);
        end
    endtask

    task automatic test_accept;
        int base;
        int unsigned t0, lat;
        apply_reset();
        base = evq.size();
        t0 = cyc;
        send_byte(8'h78, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 1) begin
            errors++;
            $display("FAIL accept_count: got %0d expected 1", evq.size() - base);
        end
        checks++;
        if (evq[base].kind !== 2'd1 || evq[base].rx !== 8'd120) begin
            errors++;
            $display("FAIL accept_event: got kind %0d rx %0d expected kind 1 rx 120",
                     evq[base].kind, evq[base].rx);
        end
        lat = evq[base].at - t0;
        checks++;
        if (lat < 614 || lat > 622) begin
            errors++;
            $display("FAIL accept_latency: got %0d cycles expected 618 +/- 4", lat);
        end
        checks++;
        if (Rx !== 8'd120) begin
            errors++;
            $display("FAIL accept_rx_hold: got %0d expected 120", Rx);
        end
    endtask

    task automatic test_range;
        int base;
        apply_reset();
        base = evq.size();
        send_byte(8'h00, BitClk, 1'b1);
        send_byte(8'hFF, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 2) begin
            errors++;
            $display("FAIL range_count: got %0d expected 2", evq.size() - base);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (evq[base + i].kind !== 2'd3 || evq[base + i].rx !== 8'd60) begin
                errors++;
                $display("FAIL range_event%0d: got kind %0d rx %0d expected kind 3 rx 60",
                         i, evq[base + i].kind, evq[base + i].rx);
            end
        end
        checks++;
        if (Rx !== 8'd60) begin
            errors++;
            $display("FAIL range_rx: got %0d expected 60", Rx);
        end
    endtask

    task automatic test_frame_error;
        int base;
        apply_reset();
        base = evq.size();
        send_byte(8'h3C, BitClk, 1'b0);
        drive_bit(1'b0, 3 * BitClk);
        checks++;
        if (evq.size() - base !== 1 || evq[base].kind !== 2'd2) begin
            errors++;
            $display("FAIL ferr_event: got count %0d kind %0d expected count 1 kind 2",
                     evq.size() - base, evq[base].kind);
        end
        drive_bit(1'b1, 2 * BitClk);
        checks++;
        if (evq.size() - base !== 1) begin
            errors++;
            $display("FAIL ferr_quiet: got %0d events expected 1", evq.size() - base);
        end
        send_byte(8'h32, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 2 || evq[base + 1].kind !== 2'd1 || Rx !== 8'd50) begin
            errors++;
            $display("FAIL ferr_recover: got count %0d kind %0d rx %0d expected 2 1 50",
                     evq.size() - base, evq[base + 1].kind, Rx);
        end
    endtask

    task automatic test_glitch;
        int base;
        apply_reset();
        base = evq.size();
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 200);
        checks++;
        if (evq.size() - base !== 0) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d events expected 0", evq.size() - base);
        end
        send_byte(8'h64, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 1 || evq[base].kind !== 2'd1 || Rx !== 8'd100) begin
            errors++;
            $display("FAIL glitch_recover: got count %0d kind %0d rx %0d expected 1 1 100",
                     evq.size() - base, evq[base].kind, Rx);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        apply_reset();
        send_byte(8'h78, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        base = evq.size();
        fork
            send_byte(8'h96, BitClk, 1'b1);
            begin
                repeat (5 * BitClk + 20) @(negedge clock);
                Restablecer = 1'b0;
                @(negedge clock);
                checks++;
                if (Rx !== 8'd60 || {Selec, ErrTrama, FueraRango} !== 3'b000) begin
                    errors++;
                    $display("FAIL midreset_state: got rx %0d strobes %b expected 60 000",
                             Rx, {Selec, ErrTrama, FueraRango});
                end
            end
        join
        Restablecer = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d events expected 0", evq.size() - base);
        end
        send_byte(8'h0A, BitClk, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (evq.size() - base !== 1 || evq[base].kind !== 2'd1 || Rx !== 8'd10) begin
            errors++;
            $display("FAIL midreset_recover: got count %0d kind %0d rx %0d expected 1 1 10",
                     evq.size() - base, evq[base].kind, Rx);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [1:0] exp_kind [3];
        logic [7:0] exp_rx   [3];
        exp_kind = '{2'd1, 2'd1, 2'd3};
        exp_rx   = '{8'd1, 8'd250, 8'd250};
        apply_reset();
        base = evq.size();
        send_byte(8'h01, FastClk, 1'b1);
        send_byte(8'hFA, FastClk, 1'b1);
        send_byte(8'hFB, FastClk, 1'b1);
        repeat (40) @(negedge clock);
        checks++;
        if (evq.size() - base !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", evq.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (evq[base + i].kind !== exp_kind[i] || evq[base + i].rx !== exp_rx[i]) begin
                errors++;
                $display("FAIL b2b_event%0d: got kind %0d rx %0d expected kind %0d rx %0d", i,
                         evq[base + i].kind, evq[base + i].rx, exp_kind[i], exp_rx[i]);
            end
        end
        checks++;
        if (Rx !== 8'd250) begin
            errors++;
            $display("FAIL b2b_rx: got %0d expected 250", Rx);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_accept();
        test_range();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
